// File: rtl/prm_shadow_pkg.sv
// p10 register defines shared by the parameter-shadow path:
// scanner FSM states and the parameter RAM word map.
package prm_shadow_pkg;

  typedef enum logic [1:0] {
    ST_SCAN   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_PEND   = 2'd2,
    ST_COMMIT = 2'd3
  } prm_state_e;

  localparam logic [7:0] ADDR_MOD_FREQ = 8'h10;
  localparam logic [7:0] ADDR_FREQ     = 8'h11;
  localparam logic [7:0] ADDR_DUTY     = 8'h12;
  localparam logic [7:0] ADDR_PHASE    = 8'h13;
  localparam logic [7:0] ADDR_DEADTIME = 8'h14;
  localparam logic [7:0] ADDR_CTRL     = 8'h15;

  localparam int PRM_LAT_MAX = 3;

  // Index counter width; a single-word mirror still needs one bit.
  function automatic int prm_idx_bits(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/prm_rd_pipe.sv
// Delay line that carries "read issued" and its word index alongside the
// parameter RAM latency, so returning data lands in the right stage slot.
module prm_rd_pipe
  import prm_shadow_pkg::*;
#(
  parameter int DEPTH    = 1,
  parameter int IDX_BITS = 3
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                issue,
  input  logic [IDX_BITS-1:0] issue_idx,
  output logic                wr_vld,
  output logic [IDX_BITS-1:0] wr_idx
);

  logic [DEPTH-1:0]               vld_r;
  logic [DEPTH-1:0][IDX_BITS-1:0] idx_r;

  // Shift issue tag and index one stage per cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_r <= {DEPTH{1'b0}};
      idx_r <= {(DEPTH*IDX_BITS){1'b0}};
    end else begin
      vld_r[0] <= issue;
      idx_r[0] <= issue_idx;
      for (int i = 1; i < DEPTH; i++) begin
        vld_r[i] <= vld_r[i-1];
        idx_r[i] <= idx_r[i-1];
      end
    end
  end

  assign wr_vld = vld_r[DEPTH-1];
  assign wr_idx = idx_r[DEPTH-1];

endmodule

// File: rtl/prm_shadow.sv
// Sweeps a window of the parameter RAM into a staging copy and commits it
// atomically to the shadow outputs, optionally aligned to a sync strobe.
module prm_shadow
  import prm_shadow_pkg::*;
#(
  parameter int N_REGS    = 8,
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 8,
  parameter int BASE_ADDR = 0,
  parameter int RAM_LAT   = 1,
  parameter int SYNC_EN   = 0
) (
  input  logic                          clk,
  input  logic                          rstn,
  output logic [ADDR_BITS-1:0]          prm_addr,
  input  logic [DATA_BITS-1:0]          prm_ram_q,
  input  logic                          hold_i,
  input  logic                          sync_i,
  output logic [N_REGS*DATA_BITS-1:0]   shadow_o,
  output logic                          upd_o,
  output logic [N_REGS-1:0]             upd_mask_o,
  output logic                          valid_o
);

  localparam int                   IDX_BITS = prm_idx_bits(N_REGS);
  localparam logic [ADDR_BITS-1:0] BASE_A   = ADDR_BITS'(BASE_ADDR);
  localparam logic [IDX_BITS-1:0]  LAST_IDX = IDX_BITS'(N_REGS - 1);
  localparam logic [1:0]           LAST_DRN = 2'(RAM_LAT - 1);
  localparam logic                 SYNC_ON  = (SYNC_EN != 0);

  prm_state_e                            state_r;
  logic [IDX_BITS-1:0]                   idx_r;
  logic [ADDR_BITS-1:0]                  addr_r;
  logic [1:0]                            drn_r;
  logic [N_REGS-1:0][DATA_BITS-1:0]      stage_r;
  logic [N_REGS-1:0][DATA_BITS-1:0]      shadow_r;
  logic                                  upd_r;
  logic [N_REGS-1:0]                     mask_r;
  logic                                  valid_r;

  logic                                  issue_s;
  logic                                  pipe_vld_s;
  logic [IDX_BITS-1:0]                   pipe_idx_s;
  logic [N_REGS-1:0]                     diff_s;
  logic                                  commit_go_s;

  // Hold may only stall a sweep that has not started yet.
  always_comb begin
    issue_s = 1'b0;
    if (state_r == ST_SCAN) begin
      issue_s = (idx_r != {IDX_BITS{1'b0}}) || !hold_i;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Changed-word mask; before the first commit every word counts as new.
  always_comb begin
    diff_s = {N_REGS{1'b0}};
    for (int i = 0; i < N_REGS; i++) begin
      diff_s[i] = (stage_r[i] != shadow_r[i]) || !valid_r;
    end
  end

  // Commit release: immediate, or gated by the sync strobe.
  always_comb begin
    commit_go_s = 1'b0;
    if (diff_s != {N_REGS{1'b0}}) begin
      commit_go_s = !SYNC_ON || sync_i;
    end else begin
      commit_go_s = 1'b0;
    end
  end

  prm_rd_pipe #(
    .DEPTH    (RAM_LAT),
    .IDX_BITS (IDX_BITS)
  ) u_rd_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .issue     (issue_s),
    .issue_idx (idx_r),
    .wr_vld    (pipe_vld_s),
    .wr_idx    (pipe_idx_s)
  );

  // Scanner FSM, stage capture and registered commit outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= ST_SCAN;
      idx_r    <= {IDX_BITS{1'b0}};
      addr_r   <= BASE_A;
      drn_r    <= 2'd0;
      stage_r  <= {(N_REGS*DATA_BITS){1'b0}};
      shadow_r <= {(N_REGS*DATA_BITS){1'b0}};
      upd_r    <= 1'b0;
      mask_r   <= {N_REGS{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      upd_r  <= 1'b0;
      mask_r <= {N_REGS{1'b0}};
      if (pipe_vld_s) begin
        stage_r[pipe_idx_s] <= prm_ram_q;
      end
      case (state_r)
        ST_SCAN: begin
          if (issue_s) begin
            if (idx_r == LAST_IDX) begin
              idx_r   <= {IDX_BITS{1'b0}};
              addr_r  <= BASE_A;
              drn_r   <= 2'd0;
              state_r <= ST_DRAIN;
            end else begin
              idx_r  <= idx_r + IDX_BITS'(1);
              addr_r <= addr_r + ADDR_BITS'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drn_r == LAST_DRN) begin
            state_r <= ST_PEND;
          end else begin
            drn_r <= drn_r + 2'd1;
          end
        end
        ST_PEND: begin
          if (diff_s == {N_REGS{1'b0}}) begin
            state_r <= ST_SCAN;
          end else if (commit_go_s) begin
            shadow_r <= stage_r;
            upd_r    <= 1'b1;
            mask_r   <= diff_s;
            valid_r  <= 1'b1;
            state_r  <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          state_r <= ST_SCAN;
        end
        default: begin
          state_r <= ST_SCAN;
        end
      endcase
    end
  end

  assign prm_addr   = addr_r;
  assign shadow_o   = shadow_r;
  assign upd_o      = upd_r;
  assign upd_mask_o = mask_r;
  assign valid_o    = valid_r;

endmodule

// File: tb/tb_prm_shadow.sv
// Bench for prm_shadow: instance A (latency 1, free-running commit) and
// instance B (latency 3, sync-gated commit) against a sweep-level model.
module tb_prm_shadow;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int BASE = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn_a, rstn_b, hold_a, hold_b, sync_a, sync_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] q_a, q_b, qb1, qb2;
  logic [N*DW-1:0] sh_a, sh_b;
  logic          upd_a, upd_b, valid_a, valid_b;
  logic [N-1:0]  mask_a, mask_b;

  logic [DW-1:0] ram [2][256];
  logic [DW-1:0] exp_sh [2][N];
  bit            exp_valid [2];
  int            n_checks, n_fail;

  prm_shadow #(.N_REGS(N), .DATA_BITS(DW), .ADDR_BITS(AW), .BASE_ADDR(BASE),
               .RAM_LAT(1), .SYNC_EN(0)) dut_a (
    .clk(clk), .rstn(rstn_a), .prm_addr(addr_a), .prm_ram_q(q_a),
    .hold_i(hold_a), .sync_i(sync_a), .shadow_o(sh_a), .upd_o(upd_a),
    .upd_mask_o(mask_a), .valid_o(valid_a));

  prm_shadow #(.N_REGS(N), .DATA_BITS(DW), .ADDR_BITS(AW), .BASE_ADDR(BASE),
               .RAM_LAT(3), .SYNC_EN(1)) dut_b (
    .clk(clk), .rstn(rstn_b), .prm_addr(addr_b), .prm_ram_q(q_b),
    .hold_i(hold_b), .sync_i(sync_b), .shadow_o(sh_b), .upd_o(upd_b),
    .upd_mask_o(mask_b), .valid_o(valid_b));

  // Parameter RAMs with 1- and 3-cycle read latency.
  always @(posedge clk) q_a <= ram[0][addr_a];
  always @(posedge clk) begin
    qb1 <= ram[1][addr_b];
    qb2 <= qb1;
    q_b <= qb2;
  end

  function automatic logic [AW-1:0] get_addr(input int d);
    return (d == 1) ? addr_b : addr_a;
  endfunction
  function automatic logic get_upd(input int d);
    return (d == 1) ? upd_b : upd_a;
  endfunction
  function automatic logic get_valid(input int d);
    return (d == 1) ? valid_b : valid_a;
  endfunction
  function automatic logic [N-1:0] get_mask(input int d);
    return (d == 1) ? mask_b : mask_a;
  endfunction
  function automatic logic [DW-1:0] get_word(input int d, input int i);
    logic [N*DW-1:0] s;
    s = (d == 1) ? sh_b : sh_a;
    return s[i*DW +: DW];
  endfunction

  task automatic set_hold(input int d, input logic v);
    if (d == 1) hold_b = v; else hold_a = v;
  endtask
  task automatic set_sync(input int d, input logic v);
    if (d == 1) sync_b = v; else sync_a = v;
  endtask
  task automatic set_rstn(input int d, input logic v);
    if (d == 1) rstn_b = v; else rstn_a = v;
  endtask

  // One sweep starting at the cycle where index 0 is (or would be) issued.
  // Expected data = RAM contents at each word's read cycle.
  task automatic run_sweep(input int d, input int hold_pre, input bit hold_mid,
                           input int wr_p, input int wr_word, input logic [DW-1:0] wr_val,
                           input int sync_wait, input int abort_p);
    logic [DW-1:0] snap [N];
    logic [N-1:0]  dmask;
    int lat;
    bit bad;
    lat = (d == 1) ? 3 : 1;
    if (hold_pre > 0) begin
      set_hold(d, 1'b1);
      for (int h = 0; h < hold_pre; h++) begin
        @(negedge clk);
        n_checks++;
        if (get_addr(d) !== AW'(BASE) || get_upd(d) !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_stall dut%0d: addr=%h upd=%b, want addr=%h upd=0",
                   d, get_addr(d), get_upd(d), AW'(BASE));
        end
      end
      set_hold(d, 1'b0);
    end
    for (int p = 0; p < N + lat; p++) begin
      if (p == abort_p) return;
      if (p == wr_p) ram[d][BASE + wr_word] = wr_val;
      if (p < N) begin
        snap[p] = ram[d][BASE + p];
        n_checks++;
        if (get_addr(d) !== AW'(BASE + p)) begin
          n_fail++;
          $display("FAIL scan_addr dut%0d p=%0d: got %h, want %h", d, p, get_addr(d), AW'(BASE + p));
        end
      end
      n_checks++;
      if (get_upd(d) !== 1'b0 || get_mask(d) !== 4'b0000 || get_valid(d) !== exp_valid[d]) begin
        n_fail++;
        $display("FAIL idle_flags dut%0d p=%0d: upd=%b mask=%b valid=%b, want 0 0000 %b",
                 d, p, get_upd(d), get_mask(d), get_valid(d), exp_valid[d]);
      end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (get_word(d, i) !== exp_sh[d][i]) begin
          n_fail++;
          $display("FAIL shadow_stable dut%0d p=%0d w%0d: got %h, want %h", d, p, i, get_word(d, i), exp_sh[d][i]);
        end
      end
      if (p == 1 && hold_mid) set_hold(d, 1'b1);
      @(negedge clk);
    end
    // PEND entry cycle
    n_checks++;
    if (get_upd(d) !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_upd dut%0d: got %b, want 0", d, get_upd(d));
    end
    dmask = 4'b0000;
    for (int i = 0; i < N; i++) begin
      if (snap[i] !== exp_sh[d][i] || !exp_valid[d]) dmask[i] = 1'b1;
    end
    if (abort_p == N + lat) return;
    if (dmask == 4'b0000) begin
      @(negedge clk);
      return;
    end
    if (d == 1) begin
      for (int w = 0; w < sync_wait; w++) begin
        if (w == 0) ram[d][BASE] = ram[d][BASE] + 32'd1;
        @(negedge clk);
        bad = (get_upd(d) !== 1'b0) || (get_addr(d) !== AW'(BASE));
        for (int i = 0; i < N; i++) if (get_word(d, i) !== exp_sh[d][i]) bad = 1'b1;
        n_checks++;
        if (bad) begin
          n_fail++;
          $display("FAIL sync_wait dut%0d w=%0d: upd=%b addr=%h, want upd=0 addr=%h shadow unchanged",
                   d, w, get_upd(d), get_addr(d), AW'(BASE));
        end
      end
      set_sync(d, 1'b1);
      @(negedge clk);
      set_sync(d, 1'b0);
    end else begin
      @(negedge clk);
    end
    // COMMIT cycle
    n_checks++;
    if (get_upd(d) !== 1'b1 || get_mask(d) !== dmask || get_valid(d) !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_flags dut%0d: upd=%b mask=%b valid=%b, want 1 %b 1",
               d, get_upd(d), get_mask(d), get_valid(d), dmask);
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (get_word(d, i) !== snap[i]) begin
        n_fail++;
        $display("FAIL commit_data dut%0d w%0d: got %h, want %h", d, i, get_word(d, i), snap[i]);
      end
      exp_sh[d][i] = snap[i];
    end
    exp_valid[d] = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset(input int d);
    set_rstn(d, 1'b0);
    #1;
    n_checks++;
    if (get_addr(d) !== AW'(BASE) || get_upd(d) !== 1'b0 || get_mask(d) !== 4'b0000 ||
        get_valid(d) !== 1'b0 || ((d == 1) ? sh_b : sh_a) !== {(N*DW){1'b0}}) begin
      n_fail++;
      $display("FAIL reset_state dut%0d: addr=%h upd=%b mask=%b valid=%b shadow=%h, want %h 0 0000 0 zero",
               d, get_addr(d), get_upd(d), get_mask(d), get_valid(d), (d == 1) ? sh_b : sh_a, AW'(BASE));
    end
    @(negedge clk);
    @(negedge clk);
    set_rstn(d, 1'b1);
    for (int i = 0; i < N; i++) exp_sh[d][i] = '0;
    exp_valid[d] = 1'b0;
  endtask

  task automatic test_first_commit(input int d);
    for (int i = 0; i < N; i++) ram[d][BASE + i] = (d == 0) ? DW'(i + 1) : $urandom;
    if (d == 1) ram[d][BASE + 1] = 32'd0;
    run_sweep(d, 0, 1'b0, -1, 0, 32'd0, 0, -1);
  endtask

  task automatic test_steady(input int d);
    for (int s = 0; s < 3; s++) run_sweep(d, 0, 1'b0, -1, 0, 32'd0, 0, -1);
  endtask

  task automatic test_midsweep_write(input int d);
    run_sweep(d, 0, 1'b0, 3, 2, 32'h0000_ABCD, 0, -1);
    run_sweep(d, 0, 1'b0, -1, 0, 32'd0, 0, -1);
  endtask

  task automatic test_sync_wait(input int d);
    run_sweep(d, 0, 1'b0, 0, 2, exp_sh[d][2] ^ 32'h0F0F_0001, 50, -1);
    run_sweep(d, 0, 1'b0, -1, 0, 32'd0, 0, -1);
  endtask

  task automatic test_hold(input int d);
    run_sweep(d, 0, 1'b0, -1, 0, 32'd0, 0, -1);
    run_sweep(d, 3, 1'b1, 1, 3, $urandom, 2, -1);
    run_sweep(d, 4, 1'b0, -1, 0, 32'd0, 1, -1);
  endtask

  task automatic test_reset_mid(input int d);
    run_sweep(d, 0, 1'b0, -1, 0, 32'd0, 0, 2);
    test_reset(d);
    run_sweep(d, 0, 1'b0, -1, 0, 32'd0, 0, -1);
    run_sweep(d, 0, 1'b0, 0, 3, exp_sh[d][3] ^ 32'h8000_0000, 0, N + 3);
    test_reset(d);
    run_sweep(d, 0, 1'b0, -1, 0, 32'd0, 0, -1);
  endtask

  task automatic test_random(input int d, input int n_sweeps);
    int wp;
    for (int s = 0; s < n_sweeps; s++) begin
      wp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N + ((d == 1) ? 3 : 1) - 1)) : -1;
      run_sweep(d, int'($urandom_range(0, 2)), 1'b0, wp, int'($urandom_range(0, N - 1)),
                $urandom, int'($urandom_range(0, 4)), -1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn_a = 1'b0; rstn_b = 1'b0;
    hold_a = 1'b0; hold_b = 1'b0;
    sync_a = 1'b0; sync_b = 1'b0;
    for (int a = 0; a < 256; a++) begin
      ram[0][a] = $urandom;
      ram[1][a] = $urandom;
    end
    repeat (2) @(negedge clk);
    test_reset(0);
    test_first_commit(0);
    test_steady(0);
    test_midsweep_write(0);
    test_random(0, 10);
    test_reset(1);
    test_first_commit(1);
    test_steady(1);
    test_sync_wait(1);
    test_hold(1);
    test_reset_mid(1);
    test_random(1, 10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
